snake_head_driver: RTL

SNAKE_HEAD_DRIVER -- requirements
Module: snake_head_driver

---
 rtl/snake_head_driver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/snake_head_driver.sv
// Snake head driver: paces moves, commits direction, tracks head position and length.
// Optional PAUSE state is compiled in when SNAKE_HEAD_PAUSE_EN is defined.
module snake_head_driver #(
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned MAX_LEN  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       apple_eaten,
  input  logic       collision,
  output logic       step,
  output logic [1:0] dir,
  output logic [7:0] length,
  output logic [2:0] head_row,
  output logic [2:0] head_col,
  output logic       running,
  output logic       game_over
);

`ifdef SNAKE_HEAD_PAUSE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2, PAUSE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;
`endif

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;
  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] LEN_INIT  = 8'(INIT_LEN);
  localparam logic [7:0] LEN_MAX   = 8'(MAX_LEN);

  state_t     state, state_next;
  logic [7:0] cnt;
  logic [1:0] pending;
  logic       run_tick, wrap, clear_cnt, restart;
  logic       btn_take;
  logic [1:0] btn_dir, rev_dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Collision outranks a pause request, and both suppress the tick wrap.
  always_comb begin
    state_next = state;
    run_tick   = 1'b0;
    wrap       = 1'b0;
    clear_cnt  = 1'b0;
    restart    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          clear_cnt  = 1'b1;
        end
      end
      RUN: begin
        if (collision) begin
          state_next = OVER;
`ifdef SNAKE_HEAD_PAUSE_EN
        end else if (start) begin
          state_next = PAUSE;
`endif
        end else begin
          run_tick = 1'b1;
          wrap     = (cnt == TICK_LAST);
        end
      end
      OVER: begin
        if (start) begin
          state_next = IDLE;
          restart    = 1'b1;
        end
      end
`ifdef SNAKE_HEAD_PAUSE_EN
      PAUSE: begin
        if (start) state_next = RUN;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Reversals are filtered out before priority, so a valid lower-priority press still lands.
  always_comb begin
    rev_dir  = dir ^ 2'b10;
    btn_take = 1'b0;
    btn_dir  = pending;
    if (btn_down  && (rev_dir != DIR_DOWN))  begin btn_take = 1'b1; btn_dir = DIR_DOWN;  end
    if (btn_right && (rev_dir != DIR_RIGHT)) begin btn_take = 1'b1; btn_dir = DIR_RIGHT; end
    if (btn_up    && (rev_dir != DIR_UP))    begin btn_take = 1'b1; btn_dir = DIR_UP;    end
    if (btn_left  && (rev_dir != DIR_LEFT))  begin btn_take = 1'b1; btn_dir = DIR_LEFT;  end
    if (state == OVER) btn_take = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      step     <= 1'b0;
      dir      <= DIR_RIGHT;
      pending  <= DIR_RIGHT;
      length   <= LEN_INIT;
      head_row <= 3'd3;
      head_col <= 3'd3;
    end else begin
      step <= wrap;
      if (clear_cnt || restart)
        cnt <= '0;
      else if (run_tick)
        cnt <= wrap ? '0 : cnt + 8'd1;
      if (restart) begin
        dir      <= DIR_RIGHT;
        pending  <= DIR_RIGHT;
        length   <= LEN_INIT;
        head_row <= 3'd3;
        head_col <= 3'd3;
      end else begin
        if (wrap) begin
          dir <= pending;
          case (pending)
            DIR_LEFT:  head_col <= head_col - 3'd1;
            DIR_UP:    head_row <= head_row - 3'd1;
            DIR_RIGHT: head_col <= head_col + 3'd1;
            default:   head_row <= head_row + 3'd1;
          endcase
        end
        if (btn_take)
          pending <= btn_dir;
        if ((state == RUN) && apple_eaten && (length < LEN_MAX))
          length <= length + 8'd1;
      end
    end
  end

  assign running   = (state == RUN);
  assign game_over = (state == OVER);

endmodule
